// File: rtl/sdram_access_arbiter.sv
// sdram_access_arbiter
// Lets the video line fetcher (reads) and the command processor (writes)
// share one single-port SDRAM controller, one burst at a time.
//   rd_req_* / rd_data* / rd_done : read requester handshake and beat stream
//   wr_req_* / wr_data* / wr_done : write requester handshake and show-ahead data
//   sdrc_*                        : SDRAM controller command/data interface
//   timeout_error                 : sticky flag, a burst stalled past TIMEOUT cycles
// Reads have fixed priority. After MAX_RD_STREAK consecutive read grants made
// while a write was waiting, the pending write is forced through.
module sdram_access_arbiter #(
    parameter int ADDR_W        = 21,
    parameter int LEN_W         = 7,
    parameter int MAX_RD_STREAK = 4,
    parameter int TIMEOUT       = 1023
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic [LEN_W-1:0]  rd_req_len,
    output logic [31:0]       rd_data,
    output logic              rd_data_valid,
    output logic              rd_done,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [LEN_W-1:0]  wr_req_len,
    input  logic [3:0]        wr_req_dqm,
    input  logic [31:0]       wr_data,
    output logic              wr_data_pop,
    output logic              wr_done,
    input  logic              sdrc_init_done,
    input  logic              sdrc_busy_n,
    output logic              sdrc_rd_n,
    output logic              sdrc_wr_n,
    output logic [ADDR_W-1:0] sdrc_addr,
    output logic [LEN_W-1:0]  sdrc_data_len,
    output logic [3:0]        sdrc_dqm,
    output logic [31:0]       sdrc_data_write,
    input  logic [31:0]       sdrc_data_read,
    input  logic              sdrc_rd_valid,
    input  logic              sdrc_wrd_ack,
    output logic              sdrc_self_refresh,
    output logic              sdrc_power_down,
    output logic              timeout_error
);

    localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);
    localparam int WD_W     = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_RD_CMD  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_WR_CMD  = 3'd4,
        ST_WR_WAIT = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [3:0]          dqm_q, dqm_d;
    logic                rd_n_q, rd_n_d;
    logic                wr_n_q, wr_n_d;
    logic                rd_done_q, rd_done_d;
    logic                wr_done_q, wr_done_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                err_q, err_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                rd_ready_s, wr_ready_s, rd_valid_s, pop_s;
    logic                grant_rd_s;
    logic                last_beat_s;

    // Next-state, latch and strobe logic for the burst sequencer.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        dqm_d      = dqm_q;
        rd_n_d     = 1'b1;
        wr_n_d     = 1'b1;
        rd_done_d  = 1'b0;
        wr_done_d  = 1'b0;
        beat_d     = beat_q;
        wd_d       = wd_q;
        err_d      = err_q;
        streak_d   = streak_q;
        rd_ready_s = 1'b0;
        wr_ready_s = 1'b0;
        rd_valid_s = 1'b0;
        pop_s      = 1'b0;
        // A write that has waited out the read streak beats a new read.
        grant_rd_s  = rd_req_valid &&
                      !(wr_req_valid && (streak_q >= STREAK_W'(MAX_RD_STREAK)));
        last_beat_s = (beat_q == len_q);

        if (!sdrc_init_done) begin
            // Controller lost initialisation: abandon any burst silently.
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT: begin
                    state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (sdrc_busy_n && grant_rd_s) begin
                        rd_ready_s = 1'b1;
                        addr_d     = rd_req_addr;
                        len_d      = rd_req_len;
                        dqm_d      = 4'b0000;
                        beat_d     = {LEN_W{1'b0}};
                        rd_n_d     = 1'b0;
                        state_d    = ST_RD_CMD;
                        if (!wr_req_valid) begin
                            streak_d = {STREAK_W{1'b0}};
                        end else if (streak_q < STREAK_W'(MAX_RD_STREAK)) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end else begin
                            streak_d = streak_q;
                        end
                    end else if (sdrc_busy_n && wr_req_valid) begin
                        wr_ready_s = 1'b1;
                        addr_d     = wr_req_addr;
                        len_d      = wr_req_len;
                        dqm_d      = wr_req_dqm;
                        beat_d     = {LEN_W{1'b0}};
                        wr_n_d     = 1'b0;
                        streak_d   = {STREAK_W{1'b0}};
                        state_d    = ST_WR_CMD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RD_CMD: begin
                    wd_d    = {WD_W{1'b0}};
                    state_d = ST_RD_WAIT;
                end
                ST_WR_CMD: begin
                    wd_d    = {WD_W{1'b0}};
                    state_d = ST_WR_WAIT;
                end
                ST_RD_WAIT: begin
                    rd_valid_s = sdrc_rd_valid;
                    // A final beat on the watchdog's last cycle still completes.
                    if (sdrc_rd_valid && last_beat_s) begin
                        rd_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (wd_q == WD_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wd_d   = wd_q + WD_W'(1);
                        beat_d = sdrc_rd_valid ? (beat_q + LEN_W'(1)) : beat_q;
                    end
                end
                ST_WR_WAIT: begin
                    pop_s = sdrc_wrd_ack;
                    if (sdrc_wrd_ack && last_beat_s) begin
                        wr_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (wd_q == WD_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wd_d   = wd_q + WD_W'(1);
                        beat_d = sdrc_wrd_ack ? (beat_q + LEN_W'(1)) : beat_q;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    // State and latched-burst registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_INIT;
            addr_q    <= {ADDR_W{1'b0}};
            len_q     <= {LEN_W{1'b0}};
            dqm_q     <= 4'b0000;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
            beat_q    <= {LEN_W{1'b0}};
            wd_q      <= {WD_W{1'b0}};
            err_q     <= 1'b0;
            streak_q  <= {STREAK_W{1'b0}};
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            dqm_q     <= dqm_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            rd_done_q <= rd_done_d;
            wr_done_q <= wr_done_d;
            beat_q    <= beat_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            streak_q  <= streak_d;
        end
    end

    // Handshakes and beat strobes are combinational so a grant or beat lands in its own cycle.
    assign rd_req_ready      = rd_ready_s;
    assign wr_req_ready      = wr_ready_s;
    assign rd_data           = sdrc_data_read;
    assign rd_data_valid     = rd_valid_s;
    assign wr_data_pop       = pop_s;
    assign rd_done           = rd_done_q;
    assign wr_done           = wr_done_q;
    assign sdrc_rd_n         = rd_n_q;
    assign sdrc_wr_n         = wr_n_q;
    assign sdrc_addr         = addr_q;
    assign sdrc_data_len     = len_q;
    assign sdrc_dqm          = dqm_q;
    assign sdrc_data_write   = wr_data;
    assign sdrc_self_refresh = 1'b0;
    assign sdrc_power_down   = 1'b0;
    assign timeout_error     = err_q;

endmodule

// File: tb/tb_sdram_access_arbiter.sv
module tb_sdram_access_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        rd_req_valid = 1'b0;
    logic        rd_req_ready;
    logic [20:0] rd_req_addr = 21'd0;
    logic [6:0]  rd_req_len = 7'd0;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic        rd_done;
    logic        wr_req_valid = 1'b0;
    logic        wr_req_ready;
    logic [20:0] wr_req_addr = 21'd0;
    logic [6:0]  wr_req_len = 7'd0;
    logic [3:0]  wr_req_dqm = 4'd0;
    logic [31:0] wr_data = 32'd0;
    logic        wr_data_pop;
    logic        wr_done;
    logic        sdrc_init_done = 1'b0;
    logic        sdrc_busy_n = 1'b1;
    logic        sdrc_rd_n;
    logic        sdrc_wr_n;
    logic [20:0] sdrc_addr;
    logic [6:0]  sdrc_data_len;
    logic [3:0]  sdrc_dqm;
    logic [31:0] sdrc_data_write;
    logic [31:0] sdrc_data_read = 32'd0;
    logic        sdrc_rd_valid = 1'b0;
    logic        sdrc_wrd_ack = 1'b0;
    logic        sdrc_self_refresh;
    logic        sdrc_power_down;
    logic        timeout_error;

    int checks = 0;
    int errors = 0;

    sdram_access_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_done(rd_done),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len), .wr_req_dqm(wr_req_dqm),
        .wr_data(wr_data), .wr_data_pop(wr_data_pop), .wr_done(wr_done),
        .sdrc_init_done(sdrc_init_done), .sdrc_busy_n(sdrc_busy_n),
        .sdrc_rd_n(sdrc_rd_n), .sdrc_wr_n(sdrc_wr_n), .sdrc_addr(sdrc_addr),
        .sdrc_data_len(sdrc_data_len), .sdrc_dqm(sdrc_dqm),
        .sdrc_data_write(sdrc_data_write), .sdrc_data_read(sdrc_data_read),
        .sdrc_rd_valid(sdrc_rd_valid), .sdrc_wrd_ack(sdrc_wrd_ack),
        .sdrc_self_refresh(sdrc_self_refresh), .sdrc_power_down(sdrc_power_down),
        .timeout_error(timeout_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_wr;
        logic [20:0] addr;
        logic [6:0]  len;
        logic [3:0]  dqm_in;
        logic [3:0]  exp_dqm;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_grant(output logic g_rd, output logic g_wr);
        int n;
        n = 0;
        #1;
        while (!(rd_req_ready || wr_req_ready) && n < 50) begin
            step();
            #1;
            n++;
        end
        g_rd = rd_req_ready;
        g_wr = wr_req_ready;
        check("grant_wait_bound", 32'(n < 50), 32'd1);
        check("never_both_ready", 32'(rd_req_ready && wr_req_ready), 32'd0);
    endtask

    task automatic do_txn(input logic is_wr, input logic [20:0] addr, input logic [6:0] len,
                          input logic [3:0] dqm_in, input logic [3:0] exp_dqm,
                          input logic [31:0] data);
        logic g_rd, g_wr;
        if (is_wr) begin
            wr_req_valid = 1'b1; wr_req_addr = addr; wr_req_len = len; wr_req_dqm = dqm_in;
        end else begin
            rd_req_valid = 1'b1; rd_req_addr = addr; rd_req_len = len; wr_req_dqm = dqm_in;
        end
        wait_grant(g_rd, g_wr);
        check("grant_rd", 32'(g_rd), 32'(!is_wr));
        check("grant_wr", 32'(g_wr), 32'(is_wr));
        step();
        // Requests change after the grant; the latched values must not follow.
        rd_req_valid = 1'b0; wr_req_valid = 1'b0;
        rd_req_addr = ~addr; wr_req_addr = ~addr;
        rd_req_len = ~len; wr_req_len = ~len; wr_req_dqm = ~dqm_in;
        #1;
        check("cmd_rd_n", 32'(sdrc_rd_n), 32'(is_wr));
        check("cmd_wr_n", 32'(sdrc_wr_n), 32'(!is_wr));
        check("cmd_addr", 32'(sdrc_addr), 32'(addr));
        check("cmd_len", 32'(sdrc_data_len), 32'(len));
        check("cmd_dqm", 32'(sdrc_dqm), 32'(exp_dqm));
        step();
        check("cmd_end_rd_n", 32'(sdrc_rd_n), 32'd1);
        check("cmd_end_wr_n", 32'(sdrc_wr_n), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            if (is_wr) begin
                sdrc_wrd_ack = 1'b1; wr_data = data + 32'(i);
                #1;
                check("wr_pop", 32'(wr_data_pop), 32'd1);
                check("wr_data_thru", sdrc_data_write, data + 32'(i));
                check("wr_done_early", 32'(wr_done), 32'd0);
            end else begin
                sdrc_rd_valid = 1'b1; sdrc_data_read = data + 32'(i);
                #1;
                check("rd_valid", 32'(rd_data_valid), 32'd1);
                check("rd_data", rd_data, data + 32'(i));
                check("rd_done_early", 32'(rd_done), 32'd0);
            end
            step();
            sdrc_wrd_ack = 1'b0; sdrc_rd_valid = 1'b0;
        end
        #1;
        check("rd_done_pulse", 32'(rd_done), 32'(!is_wr));
        check("wr_done_pulse", 32'(wr_done), 32'(is_wr));
        step();
        check("rd_done_single", 32'(rd_done), 32'd0);
        check("wr_done_single", 32'(wr_done), 32'd0);
        // Stray strobes outside a burst must not propagate.
        sdrc_wrd_ack = 1'b1; sdrc_rd_valid = 1'b1;
        #1;
        check("stray_pop", 32'(wr_data_pop), 32'd0);
        check("stray_rd_valid", 32'(rd_data_valid), 32'd0);
        sdrc_wrd_ack = 1'b0; sdrc_rd_valid = 1'b0;
    endtask

    initial begin : main
        logic g_rd, g_wr;
        logic exp_wr [10];
        logic saw_done;
        int   n;

        vecs[0] = '{1'b0, 21'h00100, 7'd0, 4'hF, 4'h0, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 21'h1FFFFF, 7'd7, 4'b0011, 4'b0011, 32'h10000000};
        vecs[2] = '{1'b0, 21'h0ABCD, 7'd3, 4'h5, 4'h0, 32'hCAFE0000};
        vecs[3] = '{1'b1, 21'h00000, 7'd0, 4'hF, 4'hF, 32'h55AA55AA};
        exp_wr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset values.
        #2 reset_n = 1'b0;
        #1;
        check("rst_rd_n", 32'(sdrc_rd_n), 32'd1);
        check("rst_wr_n", 32'(sdrc_wr_n), 32'd1);
        check("rst_addr", 32'(sdrc_addr), 32'd0);
        check("rst_len", 32'(sdrc_data_len), 32'd0);
        check("rst_dqm", 32'(sdrc_dqm), 32'd0);
        check("rst_done", 32'({rd_done, wr_done}), 32'd0);
        check("rst_err", 32'(timeout_error), 32'd0);
        check("rst_sr_pd", 32'({sdrc_self_refresh, sdrc_power_down}), 32'd0);
        step();
        step();
        reset_n = 1'b1;

        // Without init_done the arbiter stays in INIT.
        rd_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("init_hold_ready", 32'(rd_req_ready), 32'd0);
            check("init_hold_rd_n", 32'(sdrc_rd_n), 32'd1);
        end
        rd_req_valid = 1'b0;
        sdrc_init_done = 1'b1;
        step();

        // Directed burst table.
        for (int v = 0; v < 4; v++) begin
            do_txn(vecs[v].is_wr, vecs[v].addr, vecs[v].len, vecs[v].dqm_in,
                   vecs[v].exp_dqm, vecs[v].data);
        end

        // Simultaneous requests: read streak of four, then a forced write.
        rd_req_valid = 1'b1; wr_req_valid = 1'b1;
        rd_req_len = 7'd0; wr_req_len = 7'd0;
        for (int k = 0; k < 10; k++) begin
            wait_grant(g_rd, g_wr);
            check("arb_order_wr", 32'(g_wr), 32'(exp_wr[k]));
            check("arb_order_rd", 32'(g_rd), 32'(!exp_wr[k]));
            step();
            step();
            if (g_wr) sdrc_wrd_ack = 1'b1;
            else sdrc_rd_valid = 1'b1;
            step();
            sdrc_wrd_ack = 1'b0; sdrc_rd_valid = 1'b0;
        end
        rd_req_valid = 1'b0; wr_req_valid = 1'b0;
        step();

        // Busy gating.
        sdrc_busy_n = 1'b0;
        rd_req_valid = 1'b1; rd_req_addr = 21'h00042; rd_req_len = 7'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("busy_no_ready", 32'(rd_req_ready || wr_req_ready), 32'd0);
            check("busy_no_cmd", 32'({sdrc_rd_n, sdrc_wr_n}), 32'd3);
            step();
        end
        sdrc_busy_n = 1'b1;
        rd_req_valid = 1'b0;
        do_txn(1'b0, 21'h00042, 7'd0, 4'h0, 4'h0, 32'h01234567);

        // Watchdog: read of four beats that only delivers two.
        rd_req_valid = 1'b1; rd_req_addr = 21'h00300; rd_req_len = 7'd3;
        wait_grant(g_rd, g_wr);
        check("to_grant_rd", 32'(g_rd), 32'd1);
        step();
        rd_req_valid = 1'b0;
        step();
        saw_done = 1'b0;
        n = 0;
        sdrc_rd_valid = 1'b1;
        while (!timeout_error && n < 1100) begin
            step();
            n++;
            if (n >= 2) sdrc_rd_valid = 1'b0;
            if (rd_done) saw_done = 1'b1;
        end
        sdrc_rd_valid = 1'b0;
        check("to_cycles", 32'(n), 32'd1024);
        check("to_flag", 32'(timeout_error), 32'd1);
        check("to_no_done", 32'(saw_done), 32'd0);
        do_txn(1'b0, 21'h00400, 7'd1, 4'h0, 4'h0, 32'hA5A50000);
        check("to_sticky", 32'(timeout_error), 32'd1);

        // Reset in the middle of a write burst.
        wr_req_valid = 1'b1; wr_req_addr = 21'h01000; wr_req_len = 7'd7; wr_req_dqm = 4'h2;
        wait_grant(g_rd, g_wr);
        check("mid_grant_wr", 32'(g_wr), 32'd1);
        step();
        wr_req_valid = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            sdrc_wrd_ack = 1'b1;
            step();
        end
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_pop", 32'(wr_data_pop), 32'd0);
        check("mid_rst_wr_n", 32'(sdrc_wr_n), 32'd1);
        check("mid_rst_addr", 32'(sdrc_addr), 32'd0);
        check("mid_rst_len", 32'(sdrc_data_len), 32'd0);
        check("mid_rst_dqm", 32'(sdrc_dqm), 32'd0);
        check("mid_rst_err", 32'(timeout_error), 32'd0);
        sdrc_wrd_ack = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        do_txn(1'b1, 21'h02000, 7'd2, 4'h8, 4'h8, 32'h77770000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
